// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter: command codes, FSM states,
// and default geometry.
package stack_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        CMD_PEEK = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_SWAP = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        SETTLE = 2'b10,
        DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/stack_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick,
    output logic       idx
);

    always_comb begin
        idx  = 1'b0;
        pick = 2'b00;
        if (req == 2'b11) begin
            idx = ~last;
        end else begin
            idx = req[1];
        end
        if (req != 2'b00) begin
            pick = idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack_register between two requesters; rejects overflow
// and underflow using a local occupancy count.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req,
    input  logic [1:0]                 cmd0,
    input  logic [1:0]                 cmd1,
    input  logic [WIDTH-1:0]           wdata0,
    input  logic [WIDTH-1:0]           wdata1,
    output logic [1:0]                 gnt,
    output logic [1:0]                 done,
    output logic                       err,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stk_move,
    output logic                       stk_mode,
    output logic                       stk_swap,
    output logic [WIDTH-1:0]           stk_in,
    input  logic [WIDTH-1:0]           stk_top
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]    count_q, count_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic             ok_q, ok_d;
    logic             rej_q, rej_d;

    logic [1:0]       pick;
    logic             pick_idx;

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    function automatic logic legal(cmd_e c, logic [CW-1:0] n);
        logic ok;
        ok = 1'b0;
        unique case (c)
            CMD_PUSH: ok = (n < CW'(DEPTH));
            CMD_POP:  ok = (n != '0);
            CMD_SWAP: ok = (n >= CW'(2));
            CMD_PEEK: ok = (n != '0);
        endcase
        return ok;
    endfunction

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        count_d = count_q;
        last_d  = last_q;
        win_d   = win_q;
        ok_d    = ok_q;
        rej_d   = rej_q;
        unique case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    win_d   = pick_idx;
                    last_d  = pick_idx;
                    cmd_d   = pick_idx ? cmd_e'(cmd1) : cmd_e'(cmd0);
                    wdata_d = pick_idx ? wdata1 : wdata0;
                    ok_d    = legal(cmd_d, count_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rej_d = ~ok_q;
                if (ok_q && cmd_q == CMD_PUSH) begin
                    count_d = count_q + CW'(1);
                end else if (ok_q && cmd_q == CMD_POP) begin
                    count_d = count_q - CW'(1);
                end
                state_d = SETTLE;
            end
            SETTLE: begin
                // An empty stack reports 0 rather than a stale top word
                rdata_d = (count_q == '0) ? '0 : stk_top;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_PEEK;
            wdata_q <= '0;
            rdata_q <= '0;
            count_q <= '0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            ok_q    <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
            last_q  <= last_d;
            win_q   <= win_d;
            ok_q    <= ok_d;
            rej_q   <= rej_d;
        end
    end

    logic issue_ok;

    always_comb begin
        issue_ok = (state_q == ISSUE) && ok_q;
        gnt      = 2'b00;
        done     = 2'b00;
        if (state_q == ISSUE) begin
            gnt = win_q ? 2'b10 : 2'b01;
        end
        if (state_q == DONE) begin
            done = win_q ? 2'b10 : 2'b01;
        end
        err      = (state_q == DONE) && rej_q;
        stk_move = issue_ok && (cmd_q == CMD_PUSH || cmd_q == CMD_POP);
        stk_mode = issue_ok && (cmd_q == CMD_PUSH);
        stk_swap = issue_ok && (cmd_q == CMD_SWAP);
        stk_in   = (issue_ok && cmd_q == CMD_PUSH) ? wdata_q : '0;
        rdata    = rdata_q;
        count    = count_q;
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares one `stack_register` instance between two independent requesters, such as the opcode sequencer and a debug/host port. It accepts PUSH, POP, SWAP and PEEK commands over a req/gnt/done handshake and arbitrates round-robin. It tracks stack occupancy so that overflow and underflow are rejected before they reach the datapath. It drives the stack's `move`/`mode`/`swap`/`in_word` controls and returns the resulting top word to the winner.

## Interface
- `DEPTH`, 8: number of stack entries; sets the occupancy counter width to $clog2(DEPTH+1).
- `WIDTH`, 4: stack word width.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 2: request per requester; bit i belongs to requester i.
- `cmd0`, `cmd1` input 2 each: command per requester (00 PEEK, 01 PUSH, 10 POP, 11 SWAP).
- `wdata0`, `wdata1` input WIDTH each: PUSH operand per requester.
- `gnt` output 2: one-hot, one-cycle pulse marking the accepted requester.
- `done` output 2: one-hot, one-cycle pulse marking command completion.
- `err` output 1: valid while `done` is non-zero; 1 means the command was rejected.
- `rdata` output WIDTH: top of stack after the command; valid while `done` is non-zero.
- `count` output $clog2(DEPTH+1): current occupancy.
- `stk_move`, `stk_mode`, `stk_swap` output 1 each: stack controls (`stk_mode` is 1 for push, 0 for pop).
- `stk_in` output WIDTH: word presented to the stack.
- `stk_top` input WIDTH: stack top word.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, DONE.
- **IDLE:** when `req` is non-zero, pick the winner, latch its cmd and wdata, then go to ISSUE.
  - If both requesters are asking, the one not granted last wins.
  - The last-winner register resets to 1, so requester 0 wins the first tie.
- **ISSUE:** `gnt[w]`=1.
  - The legality check uses `count` as it was at entry.
  - PUSH is legal if `count`<DEPTH. It drives `stk_move`=1, `stk_mode`=1, `stk_in`=wdata.
  - POP is legal if `count`>0. It drives `stk_move`=1, `stk_mode`=0.
  - SWAP is legal if `count`≥2. It drives `stk_swap`=1.
  - PEEK is legal if `count`>0 and drives no strobes.
  - Illegal commands drive no strobes and set an internal reject flag.
  - Next state is SETTLE.
- **SETTLE:** no strobes.
  - `count` updates on entry: +1 for a legal PUSH, −1 for a legal POP, otherwise unchanged.
  - On exit, latch `rdata` ← `stk_top`, forced to 0 if the new count is 0.
  - Next state is DONE.
- **DONE:** `done[w]`=1 and `err`=reject. Next state is IDLE.
- All stack strobes and `gnt`/`done`/`err` decode from registered state only, so they are glitch-free.
- `stk_in` is 0 except in ISSUE of a PUSH.
- `req` is ignored outside IDLE.
- A requester holds `req`/`cmd`/`wdata` stable until it sees `gnt`, and should drop `req` in the `gnt` cycle. If `req` is still high at the next IDLE, it is a new request.

## Timing
- Every output resets to 0: `count`=0, state=IDLE, `rdata`=0, all strobes 0. The reject flag also resets to 0.
- Edge-by-edge sequence for a request seen at edge E0:
  - E0: accepted.
  - Between E0 and E1: `gnt` and the stack strobes are high.
  - E1: the stack updates.
  - Between E2 and E3: `done`, `err` and `rdata` are valid.
  - E3: back in IDLE.
- Command latency is 4 cycles. The earliest next grant is at edge E4, so throughput is 1 command per 4 cycles.
- Under continuous contention, grants alternate 0,1,0,1.
- Reset asserted mid-command clears state asynchronously and drops strobes immediately. No `done` is issued. The `stack_register` must be reset in the same reset domain, so `count`=0 stays consistent with it.
- The `count` boundaries are DEPTH (push rejected) and 0 (pop/peek rejected). `count` never wraps.

## Structure
- Shared package `stack_pkg` holds:
  - the command encodings: CMD_PEEK, CMD_PUSH, CMD_POP, CMD_SWAP;
  - the FSM state encoding;
  - default DEPTH and WIDTH.
- The round-robin choice lives in sub-module `rr_pick2`: inputs `req[1:0]` and `last`, outputs a one-hot `pick` and its index. It is purely combinational.
- Counter, FSM and output decode stay in `stack_arbiter`.

## Test plan
- **Reset then single PUSH:** requester 0 issues PUSH 4'h5. Expect `gnt`=01 one cycle later, `stk_move`=1/`stk_mode`=1/`stk_in`=5 for one cycle, then `done`=01, `err`=0, `rdata`=5, `count`=1.
- **Contention:** both requesters PUSH at the same edge (r0: 3, r1: 9). Expect r0 granted first and r1 four cycles later. Final `rdata`=9, `count`=2, and a subsequent SWAP leaves `rdata`=3.
- **Underflow:** POP and PEEK on an empty stack. Expect no `stk_move`, `err`=1, `rdata`=0, `count` stays 0.
- **Overflow:** push DEPTH (8) values, then a ninth PUSH. Expect the ninth to give `err`=1, no strobes, `count`=8, and `rdata` equal to the eighth value.
- **SWAP with one entry:** SWAP when `count`=1. Expect `err`=1 and no `stk_swap` pulse.
- **Mid-operation reset:** drop `rst_n` during ISSUE of a PUSH. Expect strobes low immediately, no `done`, `count`=0, and the next request served normally.
